// File: rtl/opb_pkg.sv
// opb_pkg: shared definitions for the OPB register slave.
//   OPB_AW / OPB_DW : address / data bus widths
//   OPB_NBYTES      : byte lanes per data word
//   opb_state_t     : transaction FSM states (idle, acknowledge, turnaround gap)
package opb_pkg;

    localparam int OPB_AW     = 32;
    localparam int OPB_DW     = 32;
    localparam int OPB_NBYTES = OPB_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } opb_state_t;

endpackage

// File: rtl/opb_be_merge.sv
// opb_be_merge: combinational byte-enable merge, OPB big-endian byte order.
//   old_word : current register contents ([0:31], bit 0 = MSB)
//   new_word : write data from the bus
//   be       : byte enables; be[i] selects bits [8i:8i+7] (be[0] = MSB byte)
//   merged   : new byte where enabled, old byte otherwise
module opb_be_merge
    import opb_pkg::*;
(
    input  logic [0:OPB_DW-1]     old_word,
    input  logic [0:OPB_DW-1]     new_word,
    input  logic [0:OPB_NBYTES-1] be,
    output logic [0:OPB_DW-1]     merged
);

    // With an ascending range, [8*i +: 8] is byte i counted from the MSB,
    // which lines up directly with be[i].
    always_comb begin
        merged = old_word;
        for (int i = 0; i < OPB_NBYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/opb_reg_slave.sv
// opb_reg_slave: OPB slave exposing NUM_RW read/write and NUM_RO read-only
// 32-bit registers inside the byte window [C_BASEADDR, C_HIGHADDR].
//   OPB_Clk, OPB_Rst            : clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/select : OPB master request (OPB_seqAddr ignored)
//   Sl_DBus/xferAck/errAck      : registered response; Sl_DBus is 0 unless acking
//   Sl_retry, Sl_toutSup        : tied low
//   reg_out / wr_stb            : RW register contents and per-register commit pulse
//   reg_in                      : RO register sources, sampled on the capture edge
// Each transaction is IDLE (capture) -> ACK (respond, commit write) -> GAP,
// giving a one-cycle ack and a 3-cycle minimum spacing between transfers.
module opb_reg_slave
    import opb_pkg::*;
#(
    parameter logic [OPB_AW-1:0] C_BASEADDR = 32'h0001_0000,
    parameter logic [OPB_AW-1:0] C_HIGHADDR = 32'h0001_00FF,
    parameter int                NUM_RW     = 4,
    parameter int                NUM_RO     = 4
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:OPB_AW-1]        OPB_ABus,
    input  logic [0:OPB_NBYTES-1]    OPB_BE,
    input  logic [0:OPB_DW-1]        OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:OPB_DW-1]        Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [NUM_RW*OPB_DW-1:0] reg_out,
    output logic [NUM_RW-1:0]        wr_stb,
    input  logic [NUM_RO*OPB_DW-1:0] reg_in
);

    opb_state_t                     state;
    logic [NUM_RW-1:0][OPB_DW-1:0]  regs;
    logic [NUM_RO-1:0][OPB_DW-1:0]  ro_w;

    logic [OPB_AW-1:0]              abus;
    logic [OPB_AW-1:0]              word;
    logic                           in_win;
    logic                           hit;
    logic                           mapped;
    logic [OPB_DW-1:0]              rd_mux;
    logic [NUM_RW-1:0]              rw_sel;

    logic                           cap_rnw;
    logic [0:OPB_NBYTES-1]          cap_be;
    logic [OPB_DW-1:0]              cap_wdata;
    logic [OPB_DW-1:0]              cap_rdata;
    logic [NUM_RW-1:0]              cap_sel;
    logic [OPB_DW-1:0]              merged;

    logic                           unused_seq;

    // Descending copies keep numeric value: OPB bit 0 lands on bit 31.
    assign abus       = OPB_ABus;
    assign ro_w       = reg_in;
    assign reg_out    = regs;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_seq = OPB_seqAddr;

    assign in_win = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign hit    = OPB_select && in_win;
    assign word   = (abus - C_BASEADDR) >> 2;
    assign mapped = word < 32'(NUM_RW + NUM_RO);

    // Read source and RW one-hot select for the addressed word.
    always_comb begin
        rd_mux = '0;
        rw_sel = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (word == 32'(i)) begin
                rd_mux    = regs[i];
                rw_sel[i] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (word == 32'(NUM_RW + j)) rd_mux = ro_w[j];
        end
    end

    // For an RW word cap_rdata already holds the register value, and nothing
    // else can write it before commit, so it serves as the merge base.
    opb_be_merge u_merge (
        .old_word (cap_rdata),
        .new_word (cap_wdata),
        .be       (cap_be),
        .merged   (merged)
    );

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state      <= ST_IDLE;
            Sl_DBus    <= '0;
            Sl_xferAck <= 1'b0;
            Sl_errAck  <= 1'b0;
            wr_stb     <= '0;
            regs       <= '0;
            cap_rnw    <= 1'b0;
            cap_be     <= '0;
            cap_wdata  <= '0;
            cap_rdata  <= '0;
            cap_sel    <= '0;
        end else begin
            wr_stb <= '0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        cap_rnw    <= OPB_RNW;
                        cap_be     <= OPB_BE;
                        cap_wdata  <= OPB_DBus;
                        cap_rdata  <= rd_mux;
                        cap_sel    <= rw_sel;
                        Sl_xferAck <= 1'b1;
                        Sl_errAck  <= !mapped;
                        Sl_DBus    <= OPB_RNW ? rd_mux : '0;
                        state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    Sl_xferAck <= 1'b0;
                    Sl_errAck  <= 1'b0;
                    Sl_DBus    <= '0;
                    // cap_sel is empty for RO/unmapped words, so those writes drop out.
                    if (!cap_rnw) begin
                        for (int i = 0; i < NUM_RW; i++) begin
                            if (cap_sel[i]) regs[i] <= merged;
                        end
                        wr_stb <= cap_sel;
                    end
                    state <= ST_GAP;
                end
                ST_GAP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
